verificador_hash: RTL and testbench

- Independent checker for a mining result: receives a 12-byte block plus a 4-byte candidate nonce as a byte stream, then recomputes the 24-bit micro-UCR hash iteratively.
- Compares the first two hash bytes against a target and reports valid/invalid through a held result handshake.
- Sits downstream of the nonce-search engine, or on the host link, to confirm claimed solutions without trusting the miner.

---
 rtl/verificador_hash.sv | 219 +++++++++++++++++++++
 tb/tb_verificador_hash.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_hash.sv
// verificador_hash: loads a 16-byte frame (12 block bytes + 4 nonce bytes), recomputes the 24-bit micro-UCR hash
// and flags whether its two top bytes fall below the target. Optional macro: VERIFICA_HASH_ESPERADO_EN.
module verificador_hash #(
  parameter int unsigned RONDAS_POR_CICLO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  target,
  input  logic        abortar,
  output logic        resultado_valido,
  input  logic        resultado_ack,
`ifdef VERIFICA_HASH_ESPERADO_EN
  input  logic [23:0] hash_esperado,
  output logic        coincide,
`endif
  output logic        valido,
  output logic [23:0] hash
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HASH_W    = 24;
  localparam int unsigned N_VENTANA = 16;
  localparam int unsigned N_RONDAS  = 32;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned J_W       = 5;
  localparam logic [J_W-1:0]   J_ULTIMO  = J_W'(N_RONDAS - RONDAS_POR_CICLO);
  localparam logic [J_W-1:0]   J_PASO    = J_W'(RONDAS_POR_CICLO);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(N_VENTANA - 1);

  // ARRANQUE is the one-cycle hand-off that seeds a/b/c once the window is full
  typedef enum logic [1:0] {CARGA, ARRANQUE, CALCULO, RESULTADO} estado_t;

  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   wnd_q [N_VENTANA];
  logic [BYTE_W-1:0]   wnd_d [N_VENTANA];
  logic [BYTE_W-1:0]   a_q, b_q, c_q, a_d, b_d, c_d;
  logic [J_W-1:0]      j_q, j_d;
  logic [BYTE_W-1:0]   tgt_q, tgt_d;
  logic                ready_d, rv_d, valido_d;
  logic [HASH_W-1:0]   hash_d;
`ifdef VERIFICA_HASH_ESPERADO_EN
  logic [HASH_W-1:0]   esp_q, esp_d;
  logic                coincide_d;
`endif

  // Round chain temporaries
  logic [BYTE_W-1:0]   wnd_t [N_VENTANA];
  logic [BYTE_W-1:0]   a_t, b_t, c_t, x_t, k_t, a_n, c_n, w_n;
  logic [J_W-1:0]      j_t;
  logic [HASH_W-1:0]   hash_t;
  logic                objetivo_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q         <= CARGA;
      cnt_q            <= '0;
      wnd_q            <= '{default: '0};
      a_q              <= '0;
      b_q              <= '0;
      c_q              <= '0;
      j_q              <= '0;
      tgt_q            <= '0;
      byte_ready       <= 1'b1;
      resultado_valido <= 1'b0;
      valido           <= 1'b0;
      hash             <= '0;
`ifdef VERIFICA_HASH_ESPERADO_EN
      esp_q            <= '0;
      coincide         <= 1'b0;
`endif
    end else begin
      estado_q         <= estado_d;
      cnt_q            <= cnt_d;
      wnd_q            <= wnd_d;
      a_q              <= a_d;
      b_q              <= b_d;
      c_q              <= c_d;
      j_q              <= j_d;
      tgt_q            <= tgt_d;
      byte_ready       <= ready_d;
      resultado_valido <= rv_d;
      valido           <= valido_d;
      hash             <= hash_d;
`ifdef VERIFICA_HASH_ESPERADO_EN
      esp_q            <= esp_d;
      coincide         <= coincide_d;
`endif
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    wnd_d    = wnd_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    j_d      = j_q;
    tgt_d    = tgt_q;
    ready_d  = byte_ready;
    rv_d     = resultado_valido;
    valido_d = valido;
    hash_d   = hash;
`ifdef VERIFICA_HASH_ESPERADO_EN
    esp_d      = esp_q;
    coincide_d = coincide;
`endif
    wnd_t = wnd_q;
    a_t   = a_q;
    b_t   = b_q;
    c_t   = c_q;
    x_t   = '0;
    k_t   = '0;
    a_n   = '0;
    c_n   = '0;
    w_n   = '0;
    j_t   = '0;

    // RONDAS_POR_CICLO chained rounds; the window slides one byte per round, W[j] always at index 0
    for (int unsigned r = 0; r < RONDAS_POR_CICLO; r++) begin
      j_t = j_q + J_W'(r);
      if (j_t <= J_W'(16)) begin
        x_t = a_t ^ b_t;
        k_t = 8'h99;
      end else begin
        x_t = a_t | b_t;
        k_t = 8'hA1;
      end
      c_n = x_t + k_t + wnd_t[0];
      a_n = b_t ^ c_t;
      b_t = {c_t[3:0], 4'h0};
      c_t = c_n;
      a_t = a_n;
      w_n = wnd_t[13] | (wnd_t[7] ^ wnd_t[2]);
      for (int unsigned i = 0; i < N_VENTANA - 1; i++) wnd_t[i] = wnd_t[i+1];
      wnd_t[N_VENTANA-1] = w_n;
    end

    hash_t      = {8'h01 + a_t, 8'h89 + b_t, 8'hFE + c_t};
    objetivo_ok = (hash_t[23:16] < tgt_q) && (hash_t[15:8] < tgt_q);

    case (estado_q)
      CARGA: begin
        ready_d = 1'b1;
        if (byte_valid && byte_ready) begin
          for (int unsigned i = 0; i < N_VENTANA - 1; i++) wnd_d[i] = wnd_q[i+1];
          wnd_d[N_VENTANA-1] = byte_in;
          if (cnt_q == '0) begin
            tgt_d = target;
`ifdef VERIFICA_HASH_ESPERADO_EN
            esp_d = hash_esperado;
`endif
          end
          if (cnt_q == CNT_FINAL) begin
            cnt_d    = '0;
            ready_d  = 1'b0;
            estado_d = ARRANQUE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ARRANQUE: begin
        a_d      = 8'h01;
        b_d      = 8'h89;
        c_d      = 8'hFE;
        j_d      = '0;
        estado_d = CALCULO;
      end
      CALCULO: begin
        a_d   = a_t;
        b_d   = b_t;
        c_d   = c_t;
        wnd_d = wnd_t;
        j_d   = j_q + J_PASO;
        if (j_q == J_ULTIMO) begin
          estado_d = RESULTADO;
          hash_d   = hash_t;
          rv_d     = 1'b1;
`ifdef VERIFICA_HASH_ESPERADO_EN
          coincide_d = (hash_t == esp_q);
          valido_d   = objetivo_ok && (hash_t == esp_q);
`else
          valido_d   = objetivo_ok;
`endif
        end
      end
      RESULTADO: begin
        if (resultado_ack) begin
          rv_d     = 1'b0;
          ready_d  = 1'b1;
          estado_d = CARGA;
        end
      end
      default: estado_d = CARGA;
    endcase

    // Abort wins over everything: drop the frame, keep the last published hash
    if (abortar) begin
      estado_d = CARGA;
      cnt_d    = '0;
      wnd_d    = wnd_q;
      tgt_d    = tgt_q;
      rv_d     = 1'b0;
      valido_d = 1'b0;
      ready_d  = 1'b1;
      hash_d   = hash;
`ifdef VERIFICA_HASH_ESPERADO_EN
      esp_d      = esp_q;
      coincide_d = coincide;
`endif
    end
  end

endmodule

// File: tb/tb_verificador_hash.sv
// Bench for verificador_hash: one instance at 1 round/clock and one at 4 rounds/clock fed the same stream,
// results checked against an independent 32-entry reference model through a scoreboard queue.
module tb_verificador_hash;

  typedef struct packed {
    logic [23:0] hash;
    logic        valido;
    logic        coincide;
  } esperado_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [7:0]  target;
  logic        abortar;
  logic        resultado_ack;
  logic        br1, rv1, val1, br4, rv4, val4;
  logic [23:0] h1, h4;
`ifdef VERIFICA_HASH_ESPERADO_EN
  logic [23:0] hash_esperado;
  logic        co1, co4;
`endif

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          t_acc, lat1, lat4;
  esperado_t   sb[$];
  logic [7:0]  frm [16];
  logic [23:0] ult_hash;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  verificador_hash #(.RONDAS_POR_CICLO(1)) dut1 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br1),
    .target(target), .abortar(abortar), .resultado_valido(rv1), .resultado_ack(resultado_ack),
`ifdef VERIFICA_HASH_ESPERADO_EN
    .hash_esperado(hash_esperado), .coincide(co1),
`endif
    .valido(val1), .hash(h1)
  );

  verificador_hash #(.RONDAS_POR_CICLO(4)) dut4 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br4),
    .target(target), .abortar(abortar), .resultado_valido(rv4), .resultado_ack(resultado_ack),
`ifdef VERIFICA_HASH_ESPERADO_EN
    .hash_esperado(hash_esperado), .coincide(co4),
`endif
    .valido(val4), .hash(h4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: full 32-byte schedule, plain iterative rounds
  function automatic logic [23:0] modelo(input logic [7:0] m [16]);
    logic [7:0] w [32];
    logic [7:0] a, b, c, x, k, an, bn, cn;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int j = 0; j < 32; j++) begin
      x  = (j <= 16) ? (a ^ b) : (a | b);
      k  = (j <= 16) ? 8'h99 : 8'hA1;
      an = b ^ c;
      bn = 8'(c << 4);
      cn = 8'(x + k + w[j]);
      a = an; b = bn; c = cn;
    end
    return {8'(8'h01 + a), 8'(8'h89 + b), 8'(8'hFE + c)};
  endfunction

  // Streams frm[0..n-1]; target/hash_esperado are scrambled after byte 0 to prove they are latched
  task automatic enviar(input int n, input bit huecos);
    for (int i = 0; i < n; i++) begin
      if (huecos && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      byte_in    = frm[i];
      byte_valid = 1'b1;
      for (int w = 0; w < 50 && br1 !== 1'b1; w++) @(negedge clk);
      if (i == 15) t_acc = cyc + 1;
      @(negedge clk);
      if (i == 0) begin
        target = 8'($urandom);
`ifdef VERIFICA_HASH_ESPERADO_EN
        hash_esperado = 24'($urandom);
`endif
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic esperar_resultado(input string tag, input int ack_delay, input bit ruido);
    esperado_t e;
    logic br_ok, est_ok;
    logic [23:0] h_ref;
    logic v_ref;
    lat1 = -1; lat4 = -1; br_ok = 1'b1;
    if (ruido) begin
      byte_in    = 8'hA5;
      byte_valid = 1'b1;
    end
    for (int c = 0; c < 200 && lat1 < 0; c++) begin
      @(negedge clk);
      if (br1 !== 1'b0 || br4 !== 1'b0) br_ok = 1'b0;
      if (lat4 < 0 && rv4 === 1'b1) lat4 = cyc - t_acc;
      if (rv1 === 1'b1) lat1 = cyc - t_acc;
    end
    chk({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
    e = sb.pop_front();
    ult_hash = e.hash;
    chk({tag, " lat_r1"}, 32'(lat1), 32'd33);
    chk({tag, " lat_r4"}, 32'(lat4), 32'd9);
    chk({tag, " hash_r1"}, 32'(h1), 32'(e.hash));
    chk({tag, " hash_r4"}, 32'(h4), 32'(e.hash));
    chk({tag, " valido_r1"}, 32'(val1), 32'(e.valido));
    chk({tag, " valido_r4"}, 32'(val4), 32'(e.valido));
`ifdef VERIFICA_HASH_ESPERADO_EN
    chk({tag, " coincide_r1"}, 32'(co1), 32'(e.coincide));
    chk({tag, " coincide_r4"}, 32'(co4), 32'(e.coincide));
`endif
    chk({tag, " ready_low"}, 32'(br_ok), 32'd1);
    est_ok = 1'b1; h_ref = e.hash; v_ref = e.valido;
    for (int d = 0; d < ack_delay; d++) begin
      @(negedge clk);
      if (rv1 !== 1'b1 || h1 !== h_ref || val1 !== v_ref || br1 !== 1'b0 ||
          rv4 !== 1'b1 || h4 !== h_ref || val4 !== v_ref || br4 !== 1'b0) est_ok = 1'b0;
    end
    if (ack_delay > 0) chk({tag, " hold"}, 32'(est_ok), 32'd1);
    byte_valid    = 1'b0;
    resultado_ack = 1'b1;
    @(negedge clk);
    resultado_ack = 1'b0;
    chk({tag, " rv_clear"}, 32'({rv1, rv4}), 32'd0);
    chk({tag, " ready_back"}, 32'({br1, br4}), 32'd3);
  endtask

  task automatic correr(input string tag, input logic [7:0] tgt, input bit huecos,
                        input int ack_delay, input bit ruido, input bit flip);
    esperado_t e;
    e.hash     = modelo(frm);
    e.coincide = !flip;
`ifdef VERIFICA_HASH_ESPERADO_EN
    hash_esperado = e.hash ^ {23'd0, flip};
    e.valido = (e.hash[23:16] < tgt) && (e.hash[15:8] < tgt) && e.coincide;
`else
    e.valido = (e.hash[23:16] < tgt) && (e.hash[15:8] < tgt);
`endif
    sb.push_back(e);
    target = tgt;
    enviar(16, huecos);
    esperar_resultado(tag, ack_delay, ruido);
  endtask

  initial begin
    logic ok;
    reset = 1'b0; byte_in = '0; byte_valid = 1'b0; target = '0;
    abortar = 1'b0; resultado_ack = 1'b0; ult_hash = '0;
`ifdef VERIFICA_HASH_ESPERADO_EN
    hash_esperado = '0;
`endif
    repeat (3) @(negedge clk);
    chk("reset ready", 32'({br1, br4}), 32'd3);
    chk("reset rv", 32'({rv1, rv4, val1, val4}), 32'd0);
    chk("reset hash", 32'(h1 | h4), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) frm[i] = 8'h00;
    correr("zeros_ff", 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    correr("zeros_00", 8'h00, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    correr("gaps_ack10", 8'hC0, 1'b1, 10, 1'b1, 1'b0);

    // Abort mid-load at byte 7, with a byte offered in the abort cycle
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    target = 8'hFF;
    enviar(7, 1'b0);
    byte_in = frm[7]; byte_valid = 1'b1; abortar = 1'b1;
    @(negedge clk);
    abortar = 1'b0; byte_valid = 1'b0;
    chk("abort_load state", 32'({br1, rv1, val1}), 32'b100);
    chk("abort_load hash", 32'(h1), 32'(ult_hash));
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    correr("after_abort_load", 8'hF0, 1'b0, 2, 1'b0, 1'b0);

    // Abort during compute: no result may appear for that frame
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    enviar(16, 1'b0);
    repeat (5) @(negedge clk);
    abortar = 1'b1;
    @(negedge clk);
    abortar = 1'b0;
    chk("abort_calc state", 32'({br1, rv1, val1, br4, rv4, val4}), 32'b100100);
    chk("abort_calc hash", 32'(h1), 32'(ult_hash));
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rv1 !== 1'b0 || rv4 !== 1'b0) ok = 1'b0;
    end
    chk("abort_calc no_pulse", 32'(ok), 32'd1);
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    correr("after_abort_calc", 8'h80, 1'b1, 1, 1'b0, 1'b0);

    // Asynchronous reset around round 20 of the slow instance
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    enviar(16, 1'b0);
    repeat (21) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_mid ready", 32'({br1, br4}), 32'd3);
    chk("reset_mid flags", 32'({rv1, rv4, val1, val4}), 32'd0);
    chk("reset_mid hash", 32'(h1 | h4), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    correr("after_reset", 8'hFF, 1'b0, 0, 1'b0, 1'b0);

    // Expected-hash off by one bit: coincide and valido must both drop when that feature is built in
    for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
    correr("flip_esperado", 8'hFF, 1'b0, 0, 1'b0, 1'b1);

    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
      correr("random", (f % 10 == 0) ? 8'h00 : 8'($urandom), 1'($urandom), $urandom_range(0, 3),
             1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
